uart_rx_fifo: RTL

UART receiver with an input synchronizer, start-bit validation, mid-bit sampling and a small receive FIFO. It is the receive-direction counterpart of the SoC's serial transmit path: it captures the J1 header serial input into bytes that the CPU bus adapter pops through a valid/ready handshake. Line errors (framing, overrun, and parity when enabled) are reported as sticky flags.

---
 rtl/uart_rx_fifo_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Read-side port bundle of the UART receive FIFO: show-ahead data, valid/ready pop and occupancy.
// The master side is the FIFO; the slave side is the consumer (CPU bus adapter).
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
) ();
  logic [7:0]                  rd_data;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [$clog2(FIFO_DEPTH):0] count;

  modport master (output rd_data, output rd_valid, output count, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input count, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop sync, start-bit validation, mid-bit sampling) feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a live parity_err; the default build is 8N1.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           rx,
  uart_rx_fifo_if.master rd,
  output logic           rx_busy,
  output logic           frame_err,
  output logic           overrun,
  output logic           parity_err,
  input  logic           err_clr
);
  localparam int CTR_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
  logic r_par_bad;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  state_t           r_state;
  logic [CTR_W-1:0] r_ctr;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_busy;
  logic             r_rx_meta, r_rxs;
  logic             r_frame_err, r_overrun, r_parity_err;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_bit_end, w_stop_smp, w_good, w_frame_set, w_par_set;
  logic w_full, w_pop, w_push, w_ovr_set;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_bit_end   = (r_ctr == BIT_LAST);
  assign w_stop_smp  = (r_state == S_STOP) && w_bit_end;
  assign w_frame_set = w_stop_smp && !r_rxs;
`ifdef UART_RX_PARITY_EN
  assign w_par_set = (r_state == S_PARITY) && w_bit_end && (r_rxs != ^r_shift);
  assign w_good    = w_stop_smp && r_rxs && !r_par_bad;
`else
  assign w_par_set = 1'b0;
  assign w_good    = w_stop_smp && r_rxs;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_ctr   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_ctr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_ctr == HALF_LAST) begin
            r_ctr <= '0;
            r_idx <= '0;
            if (r_rxs) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_ctr <= r_ctr + CTR_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_ctr          <= '0;
            r_shift[r_idx] <= r_rxs;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_AFTER_DATA;
          end else begin
            r_ctr <= r_ctr + CTR_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_ctr     <= '0;
            r_par_bad <= (r_rxs != ^r_shift);
            r_state   <= S_STOP;
          end else begin
            r_ctr <= r_ctr + CTR_ONE;
          end
        end
`endif
        S_STOP: begin
          // Return to IDLE on the stop sample itself so a back-to-back start bit is not missed.
          if (w_bit_end) begin
            r_ctr   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ctr <= r_ctr + CTR_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = (r_count != '0) && rd.rd_ready;
  assign w_push    = w_good && (!w_full || w_pop);
  assign w_ovr_set = w_good && w_full && !w_pop;

  // NOTE: FIFO storage is not reset; rd_valid gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_frame_err  <= (r_frame_err  & ~err_clr) | w_frame_set;
      r_overrun    <= (r_overrun    & ~err_clr) | w_ovr_set;
      r_parity_err <= (r_parity_err & ~err_clr) | w_par_set;
    end
  end

  assign rd.rd_valid = (r_count != '0);
  assign rd.rd_data  = rd.rd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign rd.count    = r_count;
  assign rx_busy     = r_busy;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign parity_err  = r_parity_err;

endmodule
